// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the in-order A result port and the FIFO-buffered
// long-latency L port onto the single regfile write port, with a starvation guard for A.
module wb_arbiter #(
  parameter int L_DEPTH    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic                       a_wen,
  input  logic [4:0]                 a_waddr,
  input  logic [31:0]                a_wdata,
  input  logic                       l_valid,
  output logic                       l_ready,
  input  logic [4:0]                 l_waddr,
  input  logic [31:0]                l_wdata,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic [$clog2(L_DEPTH):0]   l_count,
  output logic [31:0]                retire_cnt
);

  localparam int AW = $clog2(L_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_ZERO   = (AW + 1)'(0);
  localparam logic [AW:0]   DEPTH_C    = (AW + 1)'(L_DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  logic [4:0]    fifo_waddr_r [L_DEPTH];
  logic [31:0]   fifo_wdata_r [L_DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW:0]   count_r;
  logic [SW-1:0] starve_r;

  logic full_s;
  logic empty_s;
  logic gl_s;
  logic ga_s;
  logic push_s;
  logic pop_s;
  logic [4:0]  head_waddr_s;
  logic [31:0] head_wdata_s;

  // Grant decision and handshakes; L wins unless A has waited STARVE_MAX cycles.
  always_comb begin
    full_s       = (count_r == DEPTH_C);
    empty_s      = (count_r == CNT_ZERO);
    gl_s         = !empty_s && ((starve_r < STARVE_LIM) || !a_valid);
    ga_s         = a_valid && !gl_s;
    push_s       = l_valid && !full_s;
    pop_s        = gl_s;
    a_ready      = resetn && !gl_s;
    l_ready      = resetn && !full_s;
    head_waddr_s = fifo_waddr_r[rd_ptr_r];
    head_wdata_s = fifo_wdata_r[rd_ptr_r];
  end

  // L FIFO storage, pointers and occupancy.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
      for (int i = 0; i < L_DEPTH; i++) begin
        fifo_waddr_r[i] <= 5'd0;
        fifo_wdata_r[i] <= 32'd0;
      end
    end else begin
      if (push_s) begin
        fifo_waddr_r[wr_ptr_r] <= l_waddr;
        fifo_wdata_r[wr_ptr_r] <= l_wdata;
        wr_ptr_r               <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Starvation counter: consecutive cycles A has been held off by L.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      starve_r <= {SW{1'b0}};
    end else if (ga_s || !a_valid) begin
      starve_r <= {SW{1'b0}};
    end else if (gl_s && (starve_r < STARVE_LIM)) begin
      starve_r <= starve_r + STARVE_ONE;
    end else begin
      starve_r <= starve_r;
    end
  end

  // Registered regfile write; x0 destinations are consumed but never written.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
    end else if (gl_s) begin
      rf_we    <= (head_waddr_s != 5'd0);
      rf_waddr <= head_waddr_s;
      rf_wdata <= head_wdata_s;
    end else if (ga_s) begin
      rf_we    <= a_wen && (a_waddr != 5'd0);
      rf_waddr <= a_waddr;
      rf_wdata <= a_wdata;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Retired-result counter, wraps naturally at 2^32.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      retire_cnt <= 32'd0;
    end else if (gl_s || ga_s) begin
      retire_cnt <= retire_cnt + 32'd1;
    end else begin
      retire_cnt <= retire_cnt;
    end
  end

  assign l_count = count_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized bench for wb_arbiter, checked against a queue-based
// model of the grant rules.
module tb_wb_arbiter;

  localparam int L_DEPTH    = 2;
  localparam int STARVE_MAX = 3;

  logic        clock;
  logic        resetn;
  logic        a_valid;
  logic        a_ready;
  logic        a_wen;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic        l_valid;
  logic        l_ready;
  logic [4:0]  l_waddr;
  logic [31:0] l_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [$clog2(L_DEPTH):0] l_count;
  logic [31:0] retire_cnt;

  wb_arbiter #(.L_DEPTH(L_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clock(clock), .resetn(resetn),
    .a_valid(a_valid), .a_ready(a_ready), .a_wen(a_wen), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .l_valid(l_valid), .l_ready(l_ready), .l_waddr(l_waddr), .l_wdata(l_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .l_count(l_count), .retire_cnt(retire_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        lq[$];
  int          starve_m;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_retire;
  logic        obs_ar;
  logic        obs_lr;
  int          n_chk;
  int          n_pass;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    lq.delete();
    starve_m = 0;
    m_we     = 1'b0;
    m_waddr  = 5'd0;
    m_wdata  = 32'd0;
    m_retire = 32'd0;
  endtask

  task automatic set_in(input logic av, input logic wen, input logic [4:0] aa, input logic [31:0] ad,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
    a_valid = av; a_wen = wen; a_waddr = aa; a_wdata = ad;
    l_valid = lv; l_waddr = la; l_wdata = ld;
  endtask

  // One clock: check handshakes mid-cycle, advance the model, check registered outputs.
  task automatic step();
    bit   gl, ga, lr;
    ent_t e;
    @(negedge clock);
    lr = (lq.size() < L_DEPTH);
    gl = (lq.size() > 0) && ((starve_m < STARVE_MAX) || !a_valid);
    ga = a_valid && !gl;
    obs_ar = a_ready;
    obs_lr = l_ready;
    check("a_ready", a_ready, gl ? 32'd0 : 32'd1);
    check("l_ready", l_ready, lr ? 32'd1 : 32'd0);
    @(posedge clock);
    #1;
    if (gl) begin
      e = lq.pop_front();
      m_we = (e.a != 5'd0); m_waddr = e.a; m_wdata = e.d;
    end else if (ga) begin
      m_we = a_wen && (a_waddr != 5'd0); m_waddr = a_waddr; m_wdata = a_wdata;
    end else begin
      m_we = 1'b0;
    end
    if (gl || ga) m_retire = m_retire + 32'd1;
    if (l_valid && lr) begin
      e.a = l_waddr; e.d = l_wdata;
      lq.push_back(e);
    end
    if (!a_valid || ga) starve_m = 0;
    else if (starve_m < STARVE_MAX) starve_m++;
    check("rf_we", rf_we, m_we);
    check("rf_waddr", rf_waddr, m_waddr);
    check("rf_wdata", rf_wdata, m_wdata);
    check("l_count", l_count, lq.size());
    check("retire_cnt", retire_cnt, m_retire);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    bit saw_full, saw_lr0;
    n_chk = 0; n_pass = 0; n_fail = 0;
    model_reset();
    resetn = 1'b0;
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #12;
    check("rst_rf_we", rf_we, 32'd0);
    check("rst_l_count", l_count, 32'd0);
    check("rst_retire", retire_cnt, 32'd0);
    check("rst_a_ready", a_ready, 32'd0);
    check("rst_l_ready", l_ready, 32'd0);
    @(posedge clock); #1 resetn = 1'b1;

    // A write to x5
    set_in(1'b1, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'd0);
    step();
    check("t1_a_ready", obs_ar, 32'd1);
    check("t1_we", rf_we, 32'd1);
    check("t1_waddr", rf_waddr, 32'd5);
    check("t1_wdata", rf_wdata, 32'h0000_1234);
    check("t1_retire", retire_cnt, 32'd1);

    // x0 destination and retire-without-write
    set_in(1'b1, 1'b1, 5'd0, 32'h1111_1111, 1'b0, 5'd0, 32'd0);
    step();
    check("t2_x0_we", rf_we, 32'd0);
    set_in(1'b1, 1'b0, 5'd9, 32'h2222_2222, 1'b0, 5'd0, 32'd0);
    step();
    check("t2_nowen_we", rf_we, 32'd0);
    check("t2_retire", retire_cnt, 32'd3);

    // L path latency
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD_BEEF);
    step();
    check("t3_count1", l_count, 32'd1);
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    check("t3_we", rf_we, 32'd1);
    check("t3_waddr", rf_waddr, 32'd7);
    check("t3_wdata", rf_wdata, 32'hDEAD_BEEF);
    check("t3_count0", l_count, 32'd0);

    // Starvation guard and full boundary: A held valid, L pushing every cycle
    hits = 0; saw_full = 1'b0; saw_lr0 = 1'b0;
    for (int i = 0; i < 13; i++) begin
      set_in(1'b1, 1'b1, 5'(1 + (i % 31)), $urandom, 1'b1, 5'(10 + i), $urandom);
      step();
      if (obs_ar) hits++;
      if (!obs_lr) saw_lr0 = 1'b1;
      if (l_count == 2) saw_full = 1'b1;
      if (i == 5) begin
        check("full_l_ready", obs_lr, 32'd0);
        check("full_count_after_pop", l_count, 32'd1);
      end
      if (i == 6) check("push_after_full", obs_lr, 32'd1);
    end
    check("starve_a_hits", hits, 32'd4);
    check("starve_saw_full", saw_full, 32'd1);
    check("starve_saw_lready0", saw_lr0, 32'd1);

    // Reset in the middle of a cycle with a full FIFO and a pending write
    check("pre_rst_count", l_count, 32'd2);
    check("pre_rst_we", rf_we, 32'd1);
    #3 resetn = 1'b0;
    #1;
    check("mid_rst_we", rf_we, 32'd0);
    check("mid_rst_count", l_count, 32'd0);
    check("mid_rst_retire", retire_cnt, 32'd0);
    check("mid_rst_a_ready", a_ready, 32'd0);
    check("mid_rst_l_ready", l_ready, 32'd0);
    model_reset();
    @(posedge clock); @(posedge clock); #1 resetn = 1'b1;
    set_in(1'b1, 1'b0, 5'd3, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    check("post_rst_a_ready", obs_ar, 32'd1);
    check("post_rst_l_ready", obs_lr, 32'd1);
    set_in(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_no_stale", rf_we, 32'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 5'($urandom), $urandom,
             $urandom_range(0, 1) == 1,
             ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
